scoreboard_multi_warp: RTL and testbench
========================================

# scoreboard_multi_warp

Multi-warp scoreboard that tracks in-flight instructions for every warp of the SM in one block. It checks RAW/WAW/WAR hazards for each warp's head-of-IBuffer candidate in parallel and allocates a ScbID on issue grant. Entries are freed through a configurable number of clear ports from MEM, ALU and CDB. It sits between the IBuffer/issue arbiter and the Operand Collector, generalising warp count, entry depth, register-ID width and clear-port count.

## Interface
- NUM_WARPS, 8, warps tracked
- NUM_ENTRIES, 4, scoreboard entries per warp
- REG_W, 5, register ID width
- NUM_CLR, 3, clear ports (MEM, ALU, CDB by default)
- LOG_W / LOG_E, $clog2 of NUM_WARPS / NUM_ENTRIES (derived)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- src1, src2, dst  in  NUM_WARPS*REG_W each  per-warp candidate operands; warp w at [w*REG_W +: REG_W]
- src1_valid, src2_valid, dst_valid  in  NUM_WARPS each  per-warp operand valids
- issue_grant  in  1  allocate an entry for warp issue_warp this cycle
- issue_warp  in  LOG_W  granted warp
- clr_valid  in  NUM_CLR  clear request per port
- clr_warp  in  NUM_CLR*LOG_W  warp of each clear
- clr_scbid  in  NUM_CLR*LOG_E  entry of each clear
- full  out  NUM_WARPS  warp has no free entry
- dependent  out  NUM_WARPS  candidate of warp hazards with a pending entry
- ScbID_Scb_OC  out  LOG_E  entry allocated to issue_warp (lowest free index)
- warp_empty  out  NUM_WARPS  warp has no pending entries (for barrier/exit)
- err  out  2  sticky: [0] clear of non-valid entry, [1] grant to full warp

## Operation
- Per warp: valid[NUM_ENTRIES], plus src1/src2/dst and their valids per entry.
- valid_eff = valid with every matching valid clear port applied (same warp, same ScbID).
- full[w] = &valid_eff[w]; warp_empty[w] = ~|valid_eff[w].
- dependent[w] = OR over entries e with valid_eff[w][e] of:
  - RAW: candidate srcX valid, entry dst valid, equal.
  - WAW: both dst valid and equal.
  - WAR: candidate dst valid, entry srcX valid, equal.
- ScbID_Scb_OC = lowest index with ~valid_eff[issue_warp]; 0 when full.
- On issue_grant && !full[issue_warp]: write the candidate fields into that entry and set valid next cycle.
- On issue_grant && full[issue_warp]: no state change; set err[1].
- A clear hitting an entry whose registered valid is 0 sets err[0]; the clear is otherwise a no-op.
- Two ports clearing the same entry in one cycle: cleared once, no error.
- err bits clear only on reset.

## Timing
- Reset (async, rst=0): all valid=0, err=0; hence full=0, dependent=0, warp_empty=all 1, ScbID_Scb_OC=0.
- full, dependent, warp_empty and ScbID_Scb_OC are combinational from state and current-cycle inputs. Clears take effect on them in the same cycle, subject to the macro below.
- A grant is visible in dependent/full one cycle after the grant edge.
- A clear and a grant to the same entry in one cycle: the entry is freed and reallocated. It ends valid with the new contents.
- Clears to different warps, and a grant plus clears, all apply in the same cycle.
- Reset mid-operation drops all pending entries immediately. Downstream clears arriving after reset set err[0].

## Configuration
- SCB_CLR_BYPASS_EN defined: valid_eff includes same-cycle clears, so an instruction can issue in the cycle its blocker is cleared.
- Undefined: full, dependent, warp_empty and ScbID_Scb_OC use registered valid only. A clear releases dependents one cycle later, giving a shorter combinational path.
- Grant/clear state update and the err logic are identical in both builds.

## Structure
- Package scb_pkg: REG_W, default NUM_WARPS/NUM_ENTRIES/NUM_CLR, and a typedef for an entry record (src1, src2, dst, three valids).
- Sub-module scoreboard_warp_slice holds one warp's entries, hazard compare, free-slot priority encoder and err[0] detection. It is instantiated NUM_WARPS times.
- The top level does warp decode of grant and clears, muxes ScbID_Scb_OC and ORs the err bits.

## Test plan
- Reset, then read outputs -> full=0x00, dependent=0x00, warp_empty=0xFF, err=0.
- Grant warp 2 with dst=R3. Next cycle, warp 2 candidate src1=R3 -> dependent[2]=1, other warps 0, ScbID_Scb_OC=1 for warp 2.
- Fill warp 5 with 4 grants -> full[5]=1. A 5th grant -> state unchanged, err[1]=1.
- Warp 5 full; CDB clears warp 5 entry 2 in the same cycle as a grant -> with SCB_CLR_BYPASS_EN: ScbID_Scb_OC=2, entry 2 reloaded, full[5]=1 next cycle. Without the macro: full[5]=1 that cycle, grant rejected, err[1]=1.
- WAR check: pending entry src2=R7, candidate dst=R7 on the same warp -> dependent=1. MEM clears that entry -> dependent=0 same cycle (bypass) or next cycle (no bypass).
- Clear warp 0 entry 3 while it is not valid -> err[0]=1, and it stays 1 until rst is asserted.

Source files
------------

// File: rtl/scb_pkg.sv
// Shared types and defaults for the multi-warp scoreboard.
// Optional: SCB_CLR_BYPASS_EN lets same-cycle clears release hazards.
package scb_pkg;

    localparam int REG_W           = 5;
    localparam int NUM_WARPS_DEF   = 8;
    localparam int NUM_ENTRIES_DEF = 4;
    localparam int NUM_CLR_DEF     = 3;

    typedef struct packed {
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic [REG_W-1:0] dst;
        logic             src1_v;
        logic             src2_v;
        logic             dst_v;
    } scb_entry_t;

endpackage

// File: rtl/scoreboard_warp_slice.sv
// One warp's scoreboard entries, hazard compare and free-slot encoder.
// SCB_CLR_BYPASS_EN folds same-cycle clears into the visible valid set.
module scoreboard_warp_slice
    import scb_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int LOG_E       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  scb_entry_t             cand,
    input  logic                   grant,
    input  logic [NUM_ENTRIES-1:0] clr_hit,
    output logic                   full,
    output logic                   empty,
    output logic                   dependent,
    output logic [LOG_E-1:0]       free_id,
    output logic                   clr_err
);

    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] valid_eff;
    logic [NUM_ENTRIES-1:0] valid_nxt;
    scb_entry_t             ent [NUM_ENTRIES];
    logic                   accept;

`ifdef SCB_CLR_BYPASS_EN
    assign valid_eff = valid & ~clr_hit;
`else
    assign valid_eff = valid;
`endif

    assign full    = &valid_eff;
    assign empty   = ~|valid_eff;
    assign accept  = grant && !full;
    assign clr_err = |(clr_hit & ~valid);

    always_comb begin
        free_id = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (!valid_eff[e]) free_id = LOG_E'(e);
        end
    end

    always_comb begin
        dependent = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (valid_eff[e]) begin
                if (cand.src1_v && ent[e].dst_v && cand.src1 == ent[e].dst)
                    dependent = 1'b1;
                if (cand.src2_v && ent[e].dst_v && cand.src2 == ent[e].dst)
                    dependent = 1'b1;
                if (cand.dst_v && ent[e].dst_v && cand.dst == ent[e].dst)
                    dependent = 1'b1;
                if (cand.dst_v && ent[e].src1_v && cand.dst == ent[e].src1)
                    dependent = 1'b1;
                if (cand.dst_v && ent[e].src2_v && cand.dst == ent[e].src2)
                    dependent = 1'b1;
            end
        end
    end

    // clear first, so a freed slot can be refilled in the same cycle
    always_comb begin
        valid_nxt = valid & ~clr_hit;
        if (accept) valid_nxt[free_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) ent[e] <= '0;
        end else begin
            valid <= valid_nxt;
            if (accept) ent[free_id] <= cand;
        end
    end

endmodule

// File: rtl/scoreboard_multi_warp.sv
// Multi-warp scoreboard: grant/clear decode, ScbID mux and sticky errors.
// Optional: SCB_CLR_BYPASS_EN (same-cycle clear bypass, in the slices).
module scoreboard_multi_warp
    import scb_pkg::*;
#(
    parameter int NUM_WARPS   = NUM_WARPS_DEF,
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int NUM_CLR     = NUM_CLR_DEF,
    parameter int LOG_W       = $clog2(NUM_WARPS),
    parameter int LOG_E       = $clog2(NUM_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WARPS*REG_W-1:0] src1,
    input  logic [NUM_WARPS*REG_W-1:0] src2,
    input  logic [NUM_WARPS*REG_W-1:0] dst,
    input  logic [NUM_WARPS-1:0]       src1_valid,
    input  logic [NUM_WARPS-1:0]       src2_valid,
    input  logic [NUM_WARPS-1:0]       dst_valid,
    input  logic                       issue_grant,
    input  logic [LOG_W-1:0]           issue_warp,
    input  logic [NUM_CLR-1:0]         clr_valid,
    input  logic [NUM_CLR*LOG_W-1:0]   clr_warp,
    input  logic [NUM_CLR*LOG_E-1:0]   clr_scbid,
    output logic [NUM_WARPS-1:0]       full,
    output logic [NUM_WARPS-1:0]       dependent,
    output logic [LOG_E-1:0]           ScbID_Scb_OC,
    output logic [NUM_WARPS-1:0]       warp_empty,
    output logic [1:0]                 err
);

    logic [LOG_E-1:0]     free_id [NUM_WARPS];
    logic [NUM_WARPS-1:0] clr_err;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        scb_entry_t             cand;
        logic [NUM_ENTRIES-1:0] hit;
        logic                   gnt;

        assign cand.src1   = src1[w*REG_W +: REG_W];
        assign cand.src2   = src2[w*REG_W +: REG_W];
        assign cand.dst    = dst[w*REG_W +: REG_W];
        assign cand.src1_v = src1_valid[w];
        assign cand.src2_v = src2_valid[w];
        assign cand.dst_v  = dst_valid[w];
        assign gnt = issue_grant && (issue_warp == LOG_W'(w));

        // duplicate clears of one entry collapse into a single hit bit
        always_comb begin
            hit = '0;
            for (int p = 0; p < NUM_CLR; p++) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (clr_valid[p]
                        && clr_warp[p*LOG_W +: LOG_W] == LOG_W'(w)
                        && clr_scbid[p*LOG_E +: LOG_E] == LOG_E'(e))
                        hit[e] = 1'b1;
                end
            end
        end

        scoreboard_warp_slice #(
            .NUM_ENTRIES (NUM_ENTRIES),
            .LOG_E       (LOG_E)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .cand      (cand),
            .grant     (gnt),
            .clr_hit   (hit),
            .full      (full[w]),
            .empty     (warp_empty[w]),
            .dependent (dependent[w]),
            .free_id   (free_id[w]),
            .clr_err   (clr_err[w])
        );
    end

    assign ScbID_Scb_OC = free_id[issue_warp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= '0;
        end else begin
            if (|clr_err) err[0] <= 1'b1;
            if (issue_grant && full[issue_warp]) err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scoreboard_multi_warp.sv
// Self-checking bench for scoreboard_multi_warp (default and bypass builds).
module tb_scoreboard_multi_warp;

    localparam int W  = 8;
    localparam int RW = 5;
    localparam int NC = 3;
    localparam int LW = 3;
    localparam int LE = 2;

    logic            clk;
    logic            rst;
    logic [W*RW-1:0] src1, src2, dst;
    logic [W-1:0]    src1_valid, src2_valid, dst_valid;
    logic            issue_grant;
    logic [LW-1:0]   issue_warp;
    logic [NC-1:0]   clr_valid;
    logic [NC*LW-1:0] clr_warp;
    logic [NC*LE-1:0] clr_scbid;
    logic [W-1:0]    full, dependent, warp_empty;
    logic [LE-1:0]   ScbID_Scb_OC;
    logic [1:0]      err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [LE-1:0] exp_q [$];
    logic [LE-1:0] exp_id;

    scoreboard_multi_warp dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .dst          (dst),
        .src1_valid   (src1_valid),
        .src2_valid   (src2_valid),
        .dst_valid    (dst_valid),
        .issue_grant  (issue_grant),
        .issue_warp   (issue_warp),
        .clr_valid    (clr_valid),
        .clr_warp     (clr_warp),
        .clr_scbid    (clr_scbid),
        .full         (full),
        .dependent    (dependent),
        .ScbID_Scb_OC (ScbID_Scb_OC),
        .warp_empty   (warp_empty),
        .err          (err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src1 = '0; src2 = '0; dst = '0;
        src1_valid = '0; src2_valid = '0; dst_valid = '0;
        issue_grant = 0; issue_warp = '0;
        clr_valid = '0; clr_warp = '0; clr_scbid = '0;
    endtask

    task automatic set_cand(input int w, input logic [4:0] s1, input logic s1v,
                            input logic [4:0] s2, input logic s2v,
                            input logic [4:0] d, input logic dv);
        src1[w*RW +: RW] = s1; src1_valid[w] = s1v;
        src2[w*RW +: RW] = s2; src2_valid[w] = s2v;
        dst[w*RW +: RW]  = d;  dst_valid[w]  = dv;
    endtask

    task automatic set_clr(input int p, input logic [2:0] w, input logic [1:0] e);
        clr_valid[p] = 1'b1;
        clr_warp[p*LW +: LW] = w;
        clr_scbid[p*LE +: LE] = e;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        #3;
        n_cmp++; if (full !== 8'h00) begin n_bad++; $display("FAIL reset_full got %h exp 00", full); end
        n_cmp++; if (dependent !== 8'h00) begin n_bad++; $display("FAIL reset_dep got %h exp 00", dependent); end
        n_cmp++; if (warp_empty !== 8'hFF) begin n_bad++; $display("FAIL reset_empty got %h exp ff", warp_empty); end
        n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b exp 00", err); end
        n_cmp++; if (ScbID_Scb_OC !== 2'd0) begin n_bad++; $display("FAIL reset_id got %0d exp 0", ScbID_Scb_OC); end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_raw();
        idle();
        set_cand(2, 0, 0, 0, 0, 5'd3, 1);
        issue_grant = 1; issue_warp = 3'd2;
        exp_q.push_back(2'd0);
        #1;
        exp_id = exp_q.pop_front();
        n_cmp++; if (ScbID_Scb_OC !== exp_id) begin n_bad++; $display("FAIL raw_alloc got %0d exp %0d", ScbID_Scb_OC, exp_id); end
        tick();
        idle();
        issue_warp = 3'd2;
        set_cand(2, 5'd3, 1, 0, 0, 0, 0);
        #1;
        n_cmp++; if (dependent !== 8'h04) begin n_bad++; $display("FAIL raw_dep got %h exp 04", dependent); end
        n_cmp++; if (ScbID_Scb_OC !== 2'd1) begin n_bad++; $display("FAIL raw_next_id got %0d exp 1", ScbID_Scb_OC); end
        n_cmp++; if (warp_empty !== 8'hFB) begin n_bad++; $display("FAIL raw_empty got %h exp fb", warp_empty); end
        idle();
        set_clr(2, 3'd2, 2'd0);
        tick();
        idle();
        #1;
        n_cmp++; if (warp_empty !== 8'hFF) begin n_bad++; $display("FAIL raw_cleanup got %h exp ff", warp_empty); end
    endtask

    task automatic test_fill();
        idle();
        issue_warp = 3'd5;
        for (int i = 0; i < 4; i++) exp_q.push_back(LE'(i));
        for (int i = 0; i < 4; i++) begin
            issue_grant = 1;
            #1;
            exp_id = exp_q.pop_front();
            n_cmp++; if (ScbID_Scb_OC !== exp_id) begin n_bad++; $display("FAIL fill_id%0d got %0d exp %0d", i, ScbID_Scb_OC, exp_id); end
            tick();
        end
        issue_grant = 0;
        #1;
        n_cmp++; if (full !== 8'h20) begin n_bad++; $display("FAIL fill_full got %h exp 20", full); end
        n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL fill_err_pre got %b exp 00", err); end
        issue_grant = 1;
        #1;
        n_cmp++; if (ScbID_Scb_OC !== 2'd0) begin n_bad++; $display("FAIL fill_full_id got %0d exp 0", ScbID_Scb_OC); end
        tick();
        issue_grant = 0;
        #1;
        n_cmp++; if (full !== 8'h20) begin n_bad++; $display("FAIL fill_over_full got %h exp 20", full); end
        n_cmp++; if (err !== 2'b10) begin n_bad++; $display("FAIL fill_over_err got %b exp 10", err); end
        n_cmp++; if (warp_empty !== 8'hDF) begin n_bad++; $display("FAIL fill_empty got %h exp df", warp_empty); end
    endtask

    task automatic test_clear_grant();
        idle();
        issue_warp = 3'd5;
        issue_grant = 1;
        set_cand(5, 0, 0, 0, 0, 5'd9, 1);
        set_clr(2, 3'd5, 2'd2);
        #1;
`ifdef SCB_CLR_BYPASS_EN
        n_cmp++; if (ScbID_Scb_OC !== 2'd2) begin n_bad++; $display("FAIL cg_id got %0d exp 2", ScbID_Scb_OC); end
        n_cmp++; if (full !== 8'h00) begin n_bad++; $display("FAIL cg_full_now got %h exp 00", full); end
`else
        n_cmp++; if (ScbID_Scb_OC !== 2'd0) begin n_bad++; $display("FAIL cg_id got %0d exp 0", ScbID_Scb_OC); end
        n_cmp++; if (full !== 8'h20) begin n_bad++; $display("FAIL cg_full_now got %h exp 20", full); end
`endif
        tick();
        idle();
        issue_warp = 3'd5;
        set_cand(5, 5'd9, 1, 0, 0, 0, 0);
        #1;
`ifdef SCB_CLR_BYPASS_EN
        n_cmp++; if (full !== 8'h20) begin n_bad++; $display("FAIL cg_full_next got %h exp 20", full); end
        n_cmp++; if (dependent !== 8'h20) begin n_bad++; $display("FAIL cg_reload got %h exp 20", dependent); end
        n_cmp++; if (ScbID_Scb_OC !== 2'd0) begin n_bad++; $display("FAIL cg_id_next got %0d exp 0", ScbID_Scb_OC); end
`else
        n_cmp++; if (full !== 8'h00) begin n_bad++; $display("FAIL cg_full_next got %h exp 00", full); end
        n_cmp++; if (dependent !== 8'h00) begin n_bad++; $display("FAIL cg_reload got %h exp 00", dependent); end
        n_cmp++; if (ScbID_Scb_OC !== 2'd2) begin n_bad++; $display("FAIL cg_id_next got %0d exp 2", ScbID_Scb_OC); end
`endif
        n_cmp++; if (err !== 2'b10) begin n_bad++; $display("FAIL cg_err got %b exp 10", err); end
        idle();
        set_clr(0, 3'd5, 2'd0);
        set_clr(1, 3'd5, 2'd1);
        set_clr(2, 3'd5, 2'd3);
        tick();
`ifdef SCB_CLR_BYPASS_EN
        idle();
        set_clr(0, 3'd5, 2'd2);
        tick();
`endif
        idle();
        #1;
        n_cmp++; if (warp_empty !== 8'hFF) begin n_bad++; $display("FAIL cg_cleanup got %h exp ff", warp_empty); end
    endtask

    task automatic test_war();
        idle();
        issue_warp = 3'd1; issue_grant = 1;
        set_cand(1, 0, 0, 5'd7, 1, 0, 0);
        tick();
        idle();
        set_cand(1, 0, 0, 0, 0, 5'd7, 1);
        #1;
        n_cmp++; if (dependent !== 8'h02) begin n_bad++; $display("FAIL war_dep got %h exp 02", dependent); end
        set_clr(0, 3'd1, 2'd0);
        set_clr(1, 3'd1, 2'd0);
        #1;
`ifdef SCB_CLR_BYPASS_EN
        n_cmp++; if (dependent !== 8'h00) begin n_bad++; $display("FAIL war_clr_now got %h exp 00", dependent); end
`else
        n_cmp++; if (dependent !== 8'h02) begin n_bad++; $display("FAIL war_clr_now got %h exp 02", dependent); end
`endif
        tick();
        clr_valid = '0;
        #1;
        n_cmp++; if (dependent !== 8'h00) begin n_bad++; $display("FAIL war_clr_next got %h exp 00", dependent); end
        n_cmp++; if (err !== 2'b10) begin n_bad++; $display("FAIL war_dup_err got %b exp 10", err); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ws [3];
        ws[0] = 3'd3; ws[1] = 3'd4; ws[2] = 3'd6;
        idle();
        for (int i = 0; i < 3; i++) begin
            issue_grant = 1; issue_warp = ws[i];
            tick();
        end
        idle();
        #1;
        n_cmp++; if (warp_empty !== 8'hA7) begin n_bad++; $display("FAIL b2b_empty got %h exp a7", warp_empty); end
        for (int i = 0; i < 3; i++) set_clr(i, ws[i], 2'd0);
        issue_grant = 1; issue_warp = 3'd7;
        tick();
        idle();
        #1;
        n_cmp++; if (warp_empty !== 8'h7F) begin n_bad++; $display("FAIL b2b_multi_clr got %h exp 7f", warp_empty); end
        n_cmp++; if (err !== 2'b10) begin n_bad++; $display("FAIL b2b_err got %b exp 10", err); end
        set_clr(1, 3'd7, 2'd0);
        tick();
        idle();
    endtask

    task automatic test_err0();
        idle();
        set_clr(0, 3'd0, 2'd3);
        tick();
        idle();
        #1;
        n_cmp++; if (err !== 2'b11) begin n_bad++; $display("FAIL err0_set got %b exp 11", err); end
        repeat (3) tick();
        n_cmp++; if (err !== 2'b11) begin n_bad++; $display("FAIL err0_sticky got %b exp 11", err); end
        issue_grant = 1; issue_warp = 3'd6;
        tick();
        idle();
        #2;
        rst = 0;
        #1;
        n_cmp++; if (warp_empty !== 8'hFF) begin n_bad++; $display("FAIL rst_mid_empty got %h exp ff", warp_empty); end
        n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL rst_mid_err got %b exp 00", err); end
        tick();
        rst = 1;
        tick();
        set_clr(2, 3'd6, 2'd0);
        tick();
        idle();
        #1;
        n_cmp++; if (err !== 2'b01) begin n_bad++; $display("FAIL late_clr_err got %b exp 01", err); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_fill();
        test_clear_grant();
        test_war();
        test_back_to_back();
        test_err0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
